// File: rtl/writeback_unit.sv
// writeback_unit: MEM/WB pipeline register and writeback stage.
// Waits on a variable-latency data-memory response, aligns and extends load
// data, selects among ALU / load / PC+4 / CSR results and drives the
// register-file write port, with flush and back-pressure toward MEM.
// Optional feature macro: WB_RETIRE_CNT_EN (64-bit retired-instruction counter).
module writeback_unit #(
  parameter int XLEN  = 32,
  parameter int OFF_W = $clog2(XLEN/8)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_MEM,
  output logic             ready_WB,
  input  logic             flush_WB,
  input  logic [1:0]       result_set_MEM,
  input  logic             reg_write_MEM,
  input  logic [4:0]       rd_MEM,
  input  logic             load_MEM,
  input  logic [2:0]       funct3_MEM,
  input  logic [OFF_W-1:0] addr_lo_MEM,
  input  logic [XLEN-1:0]  alu_result_MEM,
  input  logic [XLEN-1:0]  pcPlus4_MEM,
  input  logic [XLEN-1:0]  csr_data_MEM,
  input  logic             mem_rvalid,
  input  logic [XLEN-1:0]  mem_rdata,
  output logic [XLEN-1:0]  write_data_WB,
  output logic [4:0]       rd_WB,
  output logic             reg_write_WB,
  output logic [63:0]      retired_count
);

  typedef enum logic [1:0] {EMPTY, WAIT, FULL} state_e;

  state_e             state_q;
  logic [1:0]         result_set_q;
  logic               reg_write_q;
  logic [4:0]         rd_q;
  logic [2:0]         funct3_q;
  logic [OFF_W-1:0]   addr_lo_q;
  logic [XLEN-1:0]    alu_q;
  logic [XLEN-1:0]    pc4_q;
  logic [XLEN-1:0]    csr_q;
  logic [XLEN-1:0]    rdata_q;

  logic [7:0]         byte_v;
  logic [15:0]        half_v;
  logic [31:0]        word_v;
  logic [XLEN-1:0]    load_data;

  // Only a pending load blocks MEM; EMPTY and FULL both accept every cycle.
  assign ready_WB = (state_q != WAIT);

  // Pipeline register and EMPTY/WAIT/FULL sequencing; flush drops everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= EMPTY;
      result_set_q <= '0;
      reg_write_q  <= 1'b0;
      rd_q         <= '0;
      funct3_q     <= '0;
      addr_lo_q    <= '0;
      alu_q        <= '0;
      pc4_q        <= '0;
      csr_q        <= '0;
      rdata_q      <= '0;
    end else if (flush_WB) begin
      state_q <= EMPTY;
    end else begin
      case (state_q)
        WAIT: begin
          if (mem_rvalid) begin
            rdata_q <= mem_rdata;
            state_q <= FULL;
          end
        end
        default: begin
          if (valid_MEM) begin
            result_set_q <= result_set_MEM;
            reg_write_q  <= reg_write_MEM;
            rd_q         <= rd_MEM;
            funct3_q     <= funct3_MEM;
            addr_lo_q    <= addr_lo_MEM;
            alu_q        <= alu_result_MEM;
            pc4_q        <= pcPlus4_MEM;
            csr_q        <= csr_data_MEM;
            if (load_MEM && !mem_rvalid) begin
              state_q <= WAIT;
            end else begin
              if (load_MEM) rdata_q <= mem_rdata;
              state_q <= FULL;
            end
          end else begin
            state_q <= EMPTY;
          end
        end
      endcase
    end
  end

  assign byte_v = rdata_q[{addr_lo_q, 3'b000} +: 8];
  assign half_v = rdata_q[{addr_lo_q[OFF_W-1:1], 4'b0000} +: 16];

  // Word lane select only exists when the datapath holds two words.
  generate
    if (XLEN == 64) begin : g_word64
      assign word_v = rdata_q[{addr_lo_q[OFF_W-1], 5'b00000} +: 32];
    end else begin : g_word32
      assign word_v = rdata_q[31:0];
    end
  endgenerate

  // Size/sign extraction; unlisted funct3 codes pass the raw data through.
  always_comb begin
    load_data = rdata_q;
    case (funct3_q)
      3'b000:  load_data = XLEN'($signed(byte_v));
      3'b100:  load_data = XLEN'(byte_v);
      3'b001:  load_data = XLEN'($signed(half_v));
      3'b101:  load_data = XLEN'(half_v);
      3'b010:  load_data = XLEN'($signed(word_v));
      3'b110:  if (XLEN == 64) load_data = XLEN'(word_v);
      default: load_data = rdata_q;
    endcase
  end

  // Result source mux driven by the registered selector.
  always_comb begin
    write_data_WB = alu_q;
    case (result_set_q)
      2'b00:   write_data_WB = alu_q;
      2'b01:   write_data_WB = load_data;
      2'b10:   write_data_WB = pc4_q;
      default: write_data_WB = csr_q;
    endcase
  end

  assign rd_WB        = rd_q;
  assign reg_write_WB = (state_q == FULL) && reg_write_q && (rd_q != 5'd0);

`ifdef WB_RETIRE_CNT_EN
  logic [63:0] retired_q;

  // Every cycle spent in FULL is one retired instruction, x0 writes included.
  always_ff @(posedge clk) begin
    if (rst) retired_q <= '0;
    else if (state_q == FULL) retired_q <= retired_q + 64'd1;
  end

  assign retired_count = retired_q;
`else
  assign retired_count = '0;
`endif

endmodule

// File: tb/tb_writeback_unit.sv
// Directed testbench for writeback_unit (XLEN=32): a table of single-cycle
// accepts applied back to back, plus hand sequences for multi-cycle loads,
// flush, and reset mid-stream.
module tb_writeback_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_MEM;
  logic        ready_WB;
  logic        flush_WB;
  logic [1:0]  result_set_MEM;
  logic        reg_write_MEM;
  logic [4:0]  rd_MEM;
  logic        load_MEM;
  logic [2:0]  funct3_MEM;
  logic [1:0]  addr_lo_MEM;
  logic [31:0] alu_result_MEM;
  logic [31:0] pcPlus4_MEM;
  logic [31:0] csr_data_MEM;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic [31:0] write_data_WB;
  logic [4:0]  rd_WB;
  logic        reg_write_WB;
  logic [63:0] retired_count;

  int unsigned n_cmp  = 0;
  int unsigned n_fail = 0;
  logic [63:0] exp_ret = '0;
  bit          in_full = 1'b0;

  writeback_unit #(.XLEN(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .valid_MEM      (valid_MEM),
    .ready_WB       (ready_WB),
    .flush_WB       (flush_WB),
    .result_set_MEM (result_set_MEM),
    .reg_write_MEM  (reg_write_MEM),
    .rd_MEM         (rd_MEM),
    .load_MEM       (load_MEM),
    .funct3_MEM     (funct3_MEM),
    .addr_lo_MEM    (addr_lo_MEM),
    .alu_result_MEM (alu_result_MEM),
    .pcPlus4_MEM    (pcPlus4_MEM),
    .csr_data_MEM   (csr_data_MEM),
    .mem_rvalid     (mem_rvalid),
    .mem_rdata      (mem_rdata),
    .write_data_WB  (write_data_WB),
    .rd_WB          (rd_WB),
    .reg_write_WB   (reg_write_WB),
    .retired_count  (retired_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  sel;
    logic        rw;
    logic [4:0]  rd;
    logic        ld;
    logic [2:0]  f3;
    logic [1:0]  al;
    logic [31:0] src;
    logic [31:0] rdata;
    logic [31:0] exp_d;
    logic        exp_we;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_ret(input string nm);
`ifdef WB_RETIRE_CNT_EN
    chk(nm, retired_count, exp_ret);
`else
    chk(nm, retired_count, 64'd0);
`endif
  endtask

  // Advance one clock; full_after says whether WB should now be in FULL.
  task automatic step(input bit full_after);
    @(posedge clk);
    #1;
    if (rst) exp_ret = '0;
    else if (in_full) exp_ret = exp_ret + 64'd1;
    in_full = full_after && !rst;
  endtask

  task automatic idle_inputs();
    valid_MEM      = 1'b0;
    flush_WB       = 1'b0;
    result_set_MEM = 2'b00;
    reg_write_MEM  = 1'b0;
    rd_MEM         = 5'd0;
    load_MEM       = 1'b0;
    funct3_MEM     = 3'b000;
    addr_lo_MEM    = 2'b00;
    alu_result_MEM = 32'h0;
    pcPlus4_MEM    = 32'h0;
    csr_data_MEM   = 32'h0;
    mem_rvalid     = 1'b0;
    mem_rdata      = 32'h0;
  endtask

  task automatic drive_alu(input logic [4:0] rd, input logic [31:0] v);
    valid_MEM      = 1'b1;
    result_set_MEM = 2'b00;
    reg_write_MEM  = 1'b1;
    rd_MEM         = rd;
    load_MEM       = 1'b0;
    alu_result_MEM = v;
  endtask

  task automatic drive_load(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] al);
    valid_MEM      = 1'b1;
    result_set_MEM = 2'b01;
    reg_write_MEM  = 1'b1;
    rd_MEM         = rd;
    load_MEM       = 1'b1;
    funct3_MEM     = f3;
    addr_lo_MEM    = al;
  endtask

  initial begin
    //          sel   rw    rd     ld    f3      al     src           rdata         exp_d         we
    vecs[0]  = '{2'd0, 1'b1, 5'd5,  1'b0, 3'b000, 2'd0, 32'h1234_5678, 32'h0,        32'h1234_5678, 1'b1};
    vecs[1]  = '{2'd1, 1'b1, 5'd6,  1'b1, 3'b101, 2'd2, 32'h0,         32'hABCD_1234, 32'h0000_ABCD, 1'b1};
    vecs[2]  = '{2'd1, 1'b1, 5'd7,  1'b1, 3'b001, 2'd2, 32'h0,         32'hABCD_1234, 32'hFFFF_ABCD, 1'b1};
    vecs[3]  = '{2'd1, 1'b1, 5'd8,  1'b1, 3'b001, 2'd0, 32'h0,         32'hABCD_8234, 32'hFFFF_8234, 1'b1};
    vecs[4]  = '{2'd1, 1'b1, 5'd9,  1'b1, 3'b000, 2'd3, 32'h0,         32'h80FF_0000, 32'hFFFF_FF80, 1'b1};
    vecs[5]  = '{2'd1, 1'b1, 5'd10, 1'b1, 3'b100, 2'd2, 32'h0,         32'h80FF_7F00, 32'h0000_00FF, 1'b1};
    vecs[6]  = '{2'd1, 1'b1, 5'd11, 1'b1, 3'b000, 2'd1, 32'h0,         32'h80FF_7F00, 32'h0000_007F, 1'b1};
    vecs[7]  = '{2'd1, 1'b1, 5'd12, 1'b1, 3'b010, 2'd0, 32'h0,         32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1};
    vecs[8]  = '{2'd1, 1'b1, 5'd13, 1'b1, 3'b001, 2'd3, 32'h0,         32'h8001_1234, 32'hFFFF_8001, 1'b1};
    vecs[9]  = '{2'd1, 1'b1, 5'd14, 1'b1, 3'b111, 2'd1, 32'h0,         32'hCAFE_F00D, 32'hCAFE_F00D, 1'b1};
    vecs[10] = '{2'd1, 1'b1, 5'd15, 1'b1, 3'b110, 2'd2, 32'h0,         32'hCAFE_F00D, 32'hCAFE_F00D, 1'b1};
    vecs[11] = '{2'd2, 1'b1, 5'd1,  1'b0, 3'b000, 2'd0, 32'h0000_0104, 32'h0,        32'h0000_0104, 1'b1};
    vecs[12] = '{2'd3, 1'b1, 5'd31, 1'b0, 3'b000, 2'd0, 32'h55AA_55AA, 32'h0,        32'h55AA_55AA, 1'b1};
    vecs[13] = '{2'd2, 1'b1, 5'd0,  1'b0, 3'b000, 2'd0, 32'h0000_0008, 32'h0,        32'h0,         1'b0};
    vecs[14] = '{2'd0, 1'b0, 5'd7,  1'b0, 3'b000, 2'd0, 32'h0000_0077, 32'h0,        32'h0,         1'b0};

    // Reset state
    idle_inputs();
    rst = 1'b1;
    step(1'b0);
    chk("rst_we",    {63'd0, reg_write_WB}, 64'd0);
    chk("rst_rd",    {59'd0, rd_WB}, 64'd0);
    chk("rst_data",  {32'd0, write_data_WB}, 64'd0);
    chk("rst_ready", {63'd0, ready_WB}, 64'd1);
    chk_ret("rst_ret");
    rst = 1'b0;

    // Table: back-to-back single-cycle accepts, loads get data at accept
    for (int i = 0; i < 15; i++) begin
      valid_MEM      = 1'b1;
      result_set_MEM = vecs[i].sel;
      reg_write_MEM  = vecs[i].rw;
      rd_MEM         = vecs[i].rd;
      load_MEM       = vecs[i].ld;
      funct3_MEM     = vecs[i].f3;
      addr_lo_MEM    = vecs[i].al;
      alu_result_MEM = (vecs[i].sel == 2'd0) ? vecs[i].src : 32'hA1A1_A1A1;
      pcPlus4_MEM    = (vecs[i].sel == 2'd2) ? vecs[i].src : 32'hB2B2_B2B2;
      csr_data_MEM   = (vecs[i].sel == 2'd3) ? vecs[i].src : 32'hC3C3_C3C3;
      mem_rvalid     = vecs[i].ld;
      mem_rdata      = vecs[i].rdata;
      step(1'b1);
      chk($sformatf("vec%0d_we", i), {63'd0, reg_write_WB}, {63'd0, vecs[i].exp_we});
      chk($sformatf("vec%0d_rd", i), {59'd0, rd_WB}, {59'd0, vecs[i].rd});
      if (vecs[i].exp_we)
        chk($sformatf("vec%0d_data", i), {32'd0, write_data_WB}, {32'd0, vecs[i].exp_d});
      chk($sformatf("vec%0d_ready", i), {63'd0, ready_WB}, 64'd1);
    end
    idle_inputs();
    step(1'b0);
    chk("drain_we", {63'd0, reg_write_WB}, 64'd0);
    chk_ret("table_ret");

    // LB with three-cycle memory latency
    drive_load(5'd3, 3'b000, 2'd3);
    mem_rdata = 32'h1111_1111;
    step(1'b0);
    idle_inputs();
    mem_rdata = 32'h2222_2222;
    chk("lb_t1_ready", {63'd0, ready_WB}, 64'd0);
    chk("lb_t1_we",    {63'd0, reg_write_WB}, 64'd0);
    step(1'b0);
    chk("lb_t2_ready", {63'd0, ready_WB}, 64'd0);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h80FF_0000;
    #1;
    chk("lb_t3_ready", {63'd0, ready_WB}, 64'd0);
    step(1'b1);
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h3333_3333;
    chk("lb_t4_we",    {63'd0, reg_write_WB}, 64'd1);
    chk("lb_t4_rd",    {59'd0, rd_WB}, 64'd3);
    chk("lb_t4_data",  {32'd0, write_data_WB}, 64'hFFFF_FF80);
    chk("lb_t4_ready", {63'd0, ready_WB}, 64'd1);
    step(1'b0);
    chk("lb_t5_we",    {63'd0, reg_write_WB}, 64'd0);
    chk_ret("lb_ret");

    // Flush while a load is pending; the late response must be ignored
    drive_load(5'd4, 3'b010, 2'd0);
    step(1'b0);
    idle_inputs();
    chk("fl_wait_ready", {63'd0, ready_WB}, 64'd0);
    flush_WB = 1'b1;
    step(1'b0);
    flush_WB   = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h5A5A_5A5A;
    chk("fl_ready", {63'd0, ready_WB}, 64'd1);
    chk("fl_we",    {63'd0, reg_write_WB}, 64'd0);
    step(1'b0);
    mem_rvalid = 1'b0;
    chk("fl_late_we", {63'd0, reg_write_WB}, 64'd0);
    chk_ret("fl_ret");

    // Flush beats an accept in the same cycle
    drive_alu(5'd9, 32'h0000_0999);
    flush_WB = 1'b1;
    step(1'b0);
    idle_inputs();
    chk("flacc_we", {63'd0, reg_write_WB}, 64'd0);

    // Reset mid-stream: first ALU retires, reset arrives with the second
    drive_alu(5'd1, 32'h0000_0AAA);
    step(1'b1);
    chk("rs_a1_we",   {63'd0, reg_write_WB}, 64'd1);
    chk("rs_a1_data", {32'd0, write_data_WB}, 64'h0000_0AAA);
    chk_ret("rs_a1_ret");
    drive_alu(5'd2, 32'h0000_0BBB);
    rst = 1'b1;
    step(1'b0);
    rst = 1'b0;
    idle_inputs();
    chk("rs_we",    {63'd0, reg_write_WB}, 64'd0);
    chk("rs_rd",    {59'd0, rd_WB}, 64'd0);
    chk("rs_data",  {32'd0, write_data_WB}, 64'd0);
    chk("rs_ready", {63'd0, ready_WB}, 64'd1);
    chk_ret("rs_ret");
    step(1'b0);
    chk("rs_after_we", {63'd0, reg_write_WB}, 64'd0);

    // Reset mid-WAIT loses the outstanding load
    drive_load(5'd6, 3'b010, 2'd0);
    step(1'b0);
    idle_inputs();
    rst = 1'b1;
    step(1'b0);
    rst        = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h1234_0000;
    chk("rw_ready", {63'd0, ready_WB}, 64'd1);
    step(1'b0);
    mem_rvalid = 1'b0;
    chk("rw_we", {63'd0, reg_write_WB}, 64'd0);
    chk_ret("rw_ret");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
